readout_sequencer: RTL and testbench

//  Sequences one readout pass of a link-readout RAM (e.g. the FMPS readout buffer) per FA strobe.
//  - Waits for the readout to settle, then walks the present-bitmap and issues RAM addresses.
//  - Emits one {index,data} packet per present entry, marking the last one.
//  - Sits between the link-readout block's RAM port and the downstream packet consumer, in the sysClk domain.

---
 rtl/readout_seq_pkg.sv | 27 ++
 rtl/readout_seq_next_index.sv | 27 ++
 rtl/readout_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_readout_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_seq_pkg.sv
// Shared types and helpers for the link-readout RAM sequencer.
package readout_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VALID,
    SCAN,
    DRAIN
  } seq_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100000;
  localparam int unsigned DEFAULT_TIMER_W        = $clog2(DEFAULT_TIMEOUT_CYCLES);

  // Widest bitmap the helper accepts; narrower bitmaps are zero-extended.
  localparam int unsigned BITMAP_MAX = 256;

  // Index of the highest set bit, 0 for an empty bitmap.
  function automatic int unsigned last_set_index(input logic [BITMAP_MAX-1:0] bitmap);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < BITMAP_MAX; i++) begin
      if (bitmap[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/readout_seq_next_index.sv
// Priority encoder: lowest set bitmap entry at or above i_from.
module readout_seq_next_index
  import readout_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [2**ADDR_WIDTH-1:0] i_bitmap,
  input  logic [ADDR_WIDTH-1:0]    i_from,
  output logic [ADDR_WIDTH-1:0]    o_index,
  output logic                     o_found
);

  localparam int unsigned NUM_ENTRIES = 2**ADDR_WIDTH;

  // Scan downward so the lowest qualifying entry is the final assignment.
  always_comb begin
    o_index = '0;
    o_found = 1'b0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (i_bitmap[i] && (ADDR_WIDTH'(i) >= i_from)) begin
        o_index = ADDR_WIDTH'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/readout_sequencer.sv
// One readout pass of a link-readout RAM per FA strobe, emitting {index,data} packets.
// Define READOUT_SEQ_SKIP_ABSENT_EN to jump straight between present entries during SCAN.
module readout_sequencer
  import readout_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     sysClk,
  input  logic                     sysReset_n,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     readoutActive,
  input  logic                     readoutValid,
  input  logic [2**ADDR_WIDTH-1:0] presentBitmap,
  output logic [ADDR_WIDTH-1:0]    readoutAddress,
  input  logic [DATA_WIDTH-1:0]    readoutData,
  output logic [ADDR_WIDTH-1:0]    packetIndex,
  output logic [DATA_WIDTH-1:0]    packetData,
  output logic                     packetValid,
  output logic                     packetLast,
  output logic                     busy,
  output logic                     donePulse,
  output logic                     timeoutPulse,
  output logic                     overrunPulse,
  output logic                     collisionPulse
);

  localparam int unsigned          NUM_ENTRIES = 2**ADDR_WIDTH;
  localparam int unsigned          TIMER_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0]   TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;

  seq_state_e             r_state, w_state_nx;
  logic [NUM_ENTRIES-1:0] r_snapshot, w_snapshot_nx;
  logic [TIMER_W-1:0]     r_timer, w_timer_nx;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nx;
  logic [ADDR_WIDTH-1:0]  r_pkt_index, w_pkt_index_nx;
  logic                   r_pkt_valid, w_pkt_valid_nx;
  logic                   r_pkt_last, w_pkt_last_nx;
  logic                   r_busy, w_busy_nx;
  logic                   r_done, w_done_nx;
  logic                   r_timeout, w_timeout_nx;
  logic                   r_overrun, w_overrun_nx;
  logic                   r_collision, w_collision_nx;

  logic                   w_hit;
  logic                   w_at_end;
  logic                   w_scan_start;
  logic [ADDR_WIDTH-1:0]  w_last_idx;
  logic [ADDR_WIDTH-1:0]  w_first_addr;
  logic [ADDR_WIDTH-1:0]  w_next_addr;

  assign w_last_idx = ADDR_WIDTH'(last_set_index(BITMAP_MAX'(r_snapshot)));
  assign w_hit      = r_snapshot[r_addr];
  assign w_at_end   = (r_addr == w_last_idx) || (r_addr == ADDR_MAX);

`ifdef READOUT_SEQ_SKIP_ABSENT_EN
  logic [ADDR_WIDTH-1:0] w_from;
  logic [ADDR_WIDTH-1:0] w_enc_index;
  logic                  w_enc_found;

  // Outside SCAN the encoder looks for the first present entry of the pass.
  assign w_from = (r_state == SCAN) ? r_addr + ADDR_WIDTH'(1) : '0;

  readout_seq_next_index #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_index (
    .i_bitmap (r_snapshot),
    .i_from   (w_from),
    .o_index  (w_enc_index),
    .o_found  (w_enc_found)
  );

  assign w_scan_start = w_enc_found;
  assign w_first_addr = w_enc_index;
  assign w_next_addr  = w_enc_index;
`else
  assign w_scan_start = 1'b1;
  assign w_first_addr = '0;
  assign w_next_addr  = r_addr + ADDR_WIDTH'(1);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nx     = r_state;
    w_snapshot_nx  = r_snapshot;
    w_timer_nx     = r_timer;
    w_addr_nx      = r_addr;
    w_pkt_index_nx = '0;
    w_pkt_valid_nx = 1'b0;
    w_pkt_last_nx  = 1'b0;
    w_done_nx      = 1'b0;
    w_timeout_nx   = 1'b0;
    w_overrun_nx   = 1'b0;
    w_collision_nx = 1'b0;

    if (start && (r_state != IDLE)) w_overrun_nx = 1'b1;

    case (r_state)
      IDLE: begin
        if (start && enable) begin
          w_snapshot_nx = presentBitmap;
          w_timer_nx    = '0;
          w_addr_nx     = '0;
          w_state_nx    = WAIT_VALID;
        end
      end
      WAIT_VALID: begin
        if (readoutValid && !readoutActive) begin
          if (w_scan_start) begin
            w_addr_nx  = w_first_addr;
            w_state_nx = SCAN;
          end else begin
            w_state_nx = DRAIN;
          end
        end else if (r_timer == TIMER_LAST) begin
          w_timeout_nx = 1'b1;
          w_state_nx   = IDLE;
        end else begin
          w_timer_nx = r_timer + TIMER_W'(1);
        end
      end
      SCAN: begin
        w_pkt_valid_nx = w_hit;
        w_pkt_index_nx = w_hit ? r_addr : '0;
        // The issue made in the collision cycle still completes, but never as last.
        if (readoutActive) begin
          w_collision_nx = 1'b1;
          w_state_nx     = IDLE;
        end else begin
          w_pkt_last_nx = w_hit && (r_addr == w_last_idx);
          if (w_at_end) w_state_nx = DRAIN;
          else          w_addr_nx  = w_next_addr;
        end
      end
      DRAIN: begin
        w_done_nx  = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase

    w_busy_nx = (w_state_nx != IDLE);
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      r_state     <= IDLE;
      r_snapshot  <= '0;
      r_timer     <= '0;
      r_addr      <= '0;
      r_pkt_index <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_snapshot  <= w_snapshot_nx;
      r_timer     <= w_timer_nx;
      r_addr      <= w_addr_nx;
      r_pkt_index <= w_pkt_index_nx;
      r_pkt_valid <= w_pkt_valid_nx;
      r_pkt_last  <= w_pkt_last_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_timeout   <= w_timeout_nx;
      r_overrun   <= w_overrun_nx;
      r_collision <= w_collision_nx;
    end
  end

  assign readoutAddress = r_addr;
  assign packetIndex    = r_pkt_index;
  assign packetValid    = r_pkt_valid;
  assign packetLast     = r_pkt_last;
  // RAM output is already registered; gate it so packetData is zero between packets.
  assign packetData     = r_pkt_valid ? readoutData : '0;
  assign busy           = r_busy;
  assign donePulse      = r_done;
  assign timeoutPulse   = r_timeout;
  assign overrunPulse   = r_overrun;
  assign collisionPulse = r_collision;

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: directed passes against a RAM model returning 0x100+addr.
module tb_readout_sequencer;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } pkt_t;

  logic          sysClk;
  logic          sysReset_n;
  logic          enable;
  logic          start;
  logic          readoutActive;
  logic          readoutValid;
  logic [31:0]   presentBitmap;
  logic [AW-1:0] readoutAddress;
  logic [DW-1:0] readoutData;
  logic [AW-1:0] packetIndex;
  logic [DW-1:0] packetData;
  logic          packetValid;
  logic          packetLast;
  logic          busy;
  logic          donePulse;
  logic          timeoutPulse;
  logic          overrunPulse;
  logic          collisionPulse;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   timeout_cnt = 0;
  int   overrun_cnt = 0;
  int   collision_cnt = 0;
  pkt_t exp_q[$];

  readout_sequencer #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sysClk         (sysClk),
    .sysReset_n     (sysReset_n),
    .enable         (enable),
    .start          (start),
    .readoutActive  (readoutActive),
    .readoutValid   (readoutValid),
    .presentBitmap  (presentBitmap),
    .readoutAddress (readoutAddress),
    .readoutData    (readoutData),
    .packetIndex    (packetIndex),
    .packetData     (packetData),
    .packetValid    (packetValid),
    .packetLast     (packetLast),
    .busy           (busy),
    .donePulse      (donePulse),
    .timeoutPulse   (timeoutPulse),
    .overrunPulse   (overrunPulse),
    .collisionPulse (collisionPulse)
  );

  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  // RAM with one-cycle read latency; word at address a holds 0x100+a.
  always @(posedge sysClk) readoutData <= 32'h100 + 32'(readoutAddress);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare each packet, tally the pulses.
  initial forever begin
    pkt_t e;
    @(negedge sysClk);
    if (sysReset_n) begin
      if (packetValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_packet: got idx=%0d data=0x%0h last=%0b expected none",
                   packetIndex, packetData, packetLast);
        end else begin
          e = exp_q.pop_front();
          chk("packet", 64'({packetIndex, packetData, packetLast}), 64'(e));
        end
      end
      if (donePulse)      done_cnt++;
      if (timeoutPulse)   timeout_cnt++;
      if (overrunPulse)   overrun_cnt++;
      if (collisionPulse) collision_cnt++;
    end
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic push(input int idx, input logic last);
    pkt_t p;
    p.idx  = AW'(idx);
    p.data = 32'h100 + 32'(idx);
    p.last = last;
    exp_q.push_back(p);
  endtask

  // Bitmap is cleared right after the strobe so the snapshot is what gets used.
  task automatic start_pass(input logic [31:0] bm);
    presentBitmap = bm;
    enable        = 1'b1;
    start         = 1'b1;
    tick();
    start         = 1'b0;
    presentBitmap = '0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      tick();
      n++;
    end
    chk(name, 64'(done_cnt), 64'(target));
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({readoutAddress, packetIndex, packetValid, packetLast, busy,
                donePulse, timeoutPulse, overrunPulse, collisionPulse});
  endfunction

  initial begin
    int d0, t0, o0, c0, n;
    sysReset_n    = 1'b0;
    enable        = 1'b0;
    start         = 1'b0;
    readoutActive = 1'b0;
    readoutValid  = 1'b0;
    presentBitmap = '0;
    repeat (3) tick();
    chk("reset_outputs", all_outputs(), 64'd0);
    chk("reset_data", 64'(packetData), 64'd0);
    sysReset_n = 1'b1;
    tick();

    // start with enable low is ignored
    presentBitmap = 32'h5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("disabled_busy", 64'(busy), 64'd0);
    chk("disabled_overrun", 64'(overrun_cnt), 64'd0);

    // two present entries
    d0 = done_cnt;
    push(0, 1'b0);
    push(2, 1'b1);
    start_pass(32'h5);
    repeat (2) tick();
    readoutValid = 1'b1;
    wait_done(d0 + 1, "s1_done");
    readoutValid = 1'b0;
    chk("s1_queue", 64'(exp_q.size()), 64'd0);
    chk("s1_busy", 64'(busy), 64'd0);

    // empty bitmap
    d0 = done_cnt;
    start_pass(32'h0);
    readoutValid = 1'b1;
    wait_done(d0 + 1, "s2_done");
    readoutValid = 1'b0;
    tick();
    chk("s2_busy", 64'(busy), 64'd0);
    chk("s2_done_once", 64'(done_cnt), 64'(d0 + 1));

    // timeout with readoutValid never rising
    t0 = timeout_cnt;
    d0 = done_cnt;
    start_pass(32'h5);
    n = 0;
    while (!timeoutPulse && n < 40) begin
      tick();
      n++;
    end
    chk("s3_timeout_latency", 64'(n), 64'(TO));
    tick();
    chk("s3_timeout_cnt", 64'(timeout_cnt), 64'(t0 + 1));
    chk("s3_no_done", 64'(done_cnt), 64'(d0));
    chk("s3_busy", 64'(busy), 64'd0);

    // valid arriving on the terminal timer cycle wins
    t0 = timeout_cnt;
    d0 = done_cnt;
    push(1, 1'b1);
    start_pass(32'h2);
    repeat (TO - 1) tick();
    readoutValid = 1'b1;
    wait_done(d0 + 1, "tie_done");
    readoutValid = 1'b0;
    chk("tie_no_timeout", 64'(timeout_cnt), 64'(t0));
    chk("tie_queue", 64'(exp_q.size()), 64'd0);

    // full bitmap with an overrun strobe mid-scan
    o0 = overrun_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) push(i, i == 31);
    start_pass(32'hFFFF_FFFF);
    repeat (2) tick();
    readoutValid = 1'b1;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0 + 1, "s4_done");
    readoutValid = 1'b0;
    repeat (3) tick();
    chk("s4_overrun", 64'(overrun_cnt), 64'(o0 + 1));
    chk("s4_queue", 64'(exp_q.size()), 64'd0);
    chk("s4_busy", 64'(busy), 64'd0);

    // collision on the 4th SCAN cycle
    c0 = collision_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) push(i, 1'b0);
    start_pass(32'hFFFF_FFFF);
    repeat (2) tick();
    readoutValid = 1'b1;
    repeat (4) tick();
    readoutActive = 1'b1;
    tick();
    readoutActive = 1'b0;
    readoutValid  = 1'b0;
    repeat (5) tick();
    chk("s5_collision", 64'(collision_cnt), 64'(c0 + 1));
    chk("s5_no_done", 64'(done_cnt), 64'(d0));
    chk("s5_queue", 64'(exp_q.size()), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);

    // only the top entry present
    d0 = done_cnt;
    push(31, 1'b1);
    start_pass(32'h8000_0000);
    readoutValid = 1'b1;
    wait_done(d0 + 1, "s7_done");
    readoutValid = 1'b0;
    chk("s7_queue", 64'(exp_q.size()), 64'd0);

    // reset mid-scan, then a clean pass
    t0 = timeout_cnt;
    o0 = overrun_cnt;
    c0 = collision_cnt;
    push(0, 1'b0);
    push(1, 1'b0);
    start_pass(32'hFFFF_FFFF);
    repeat (2) tick();
    readoutValid = 1'b1;
    repeat (3) tick();
    #5;
    sysReset_n = 1'b0;
    #1;
    chk("s6_reset_outputs", all_outputs(), 64'd0);
    chk("s6_reset_data", 64'(packetData), 64'd0);
    chk("s6_queue", 64'(exp_q.size()), 64'd0);
    readoutValid = 1'b0;
    tick();
    sysReset_n = 1'b1;
    tick();
    d0 = done_cnt;
    push(0, 1'b0);
    push(2, 1'b1);
    start_pass(32'h5);
    repeat (2) tick();
    readoutValid = 1'b1;
    wait_done(d0 + 1, "s6_clean_done");
    readoutValid = 1'b0;
    chk("s6_clean_queue", 64'(exp_q.size()), 64'd0);
    chk("s6_no_stray_pulses", 64'({timeout_cnt[15:0], overrun_cnt[15:0], collision_cnt[15:0]}),
        64'({t0[15:0], o0[15:0], c0[15:0]}));

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
